// File: rtl/decode_issue.sv
// Single-entry decode/issue stage: holds one pre-decoded instruction, blocks it
// while any register it touches has a pending write, and hands it downstream.
module decode_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_pc,
  input  logic [2:0]  in_rs_adr,
  input  logic [2:0]  in_rd_adr,
  input  logic        in_rs_use,
  input  logic        in_rd_use,
  input  logic        in_regwrite,
  input  logic        in_from_mem,
  input  logic [23:0] register_invalid,
  input  logic        flush_decode,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [15:0] issue_pc,
  output logic [2:0]  issue_rs_adr,
  output logic [2:0]  issue_rd_adr,
  output logic        regwrite_cur,
  output logic [2:0]  regwrite_adr_id,
  output logic        from_main_mem_id,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  rs_adr_q, rs_adr_d;
  logic [2:0]  rd_adr_q, rd_adr_d;
  logic        rs_use_q, rs_use_d;
  logic        rd_use_q, rd_use_d;
  logic        regwrite_q, regwrite_d;
  logic        from_mem_q, from_mem_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [7:0]  reg_busy;
  logic        hazard;
  logic        fire;
  logic        accept;

  // A register is busy while its pending-write counter is nonzero.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_busy
      assign reg_busy[gi] = |register_invalid[gi*3 +: 3];
    end
  endgenerate

  always_comb begin
    hazard = (rs_use_q & reg_busy[rs_adr_q])
           | (rd_use_q & reg_busy[rd_adr_q])
           | (regwrite_q & reg_busy[rd_adr_q]);
  end

  // Outputs are forced low while reset is held so nothing escapes in reset cycles.
  always_comb begin
    issue_valid = reset & (state_q == ST_HELD) & ~hazard & ~flush_decode;
    fire        = issue_valid & issue_ready;
    in_ready    = reset & ((state_q == ST_EMPTY) | fire) & ~flush_decode;
    accept      = in_valid & in_ready;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rs_adr_d    = rs_adr_q;
    rd_adr_d    = rd_adr_q;
    rs_use_d    = rs_use_q;
    rd_use_d    = rd_use_q;
    regwrite_d  = regwrite_q;
    from_mem_d  = from_mem_q;
    stall_cnt_d = stall_cnt_q;

    if (flush_decode) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_HELD;
        ST_HELD: begin
          if (fire) begin
            state_d = accept ? ST_HELD : ST_EMPTY;
          end else if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end
        ST_FLUSH: state_d = ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end

    if (accept) begin
      pc_d       = in_pc;
      rs_adr_d   = in_rs_adr;
      rd_adr_d   = in_rd_adr;
      rs_use_d   = in_rs_use;
      rd_use_d   = in_rd_use;
      regwrite_d = in_regwrite;
      from_mem_d = in_from_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      pc_q        <= '0;
      rs_adr_q    <= '0;
      rd_adr_q    <= '0;
      rs_use_q    <= 1'b0;
      rd_use_q    <= 1'b0;
      regwrite_q  <= 1'b0;
      from_mem_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rs_adr_q    <= rs_adr_d;
      rd_adr_q    <= rd_adr_d;
      rs_use_q    <= rs_use_d;
      rd_use_q    <= rd_use_d;
      regwrite_q  <= regwrite_d;
      from_mem_q  <= from_mem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    issue_pc         = pc_q;
    issue_rs_adr     = rs_adr_q;
    issue_rd_adr     = rd_adr_q;
    regwrite_cur     = fire & regwrite_q;
    regwrite_adr_id  = rd_adr_q;
    from_main_mem_id = from_mem_q;
    stall_cnt        = stall_cnt_q;
  end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: hand-computed expectations for reset,
// hazard stalls, back-to-back issue, loads, flush and stall-counter saturation.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc;
  logic [2:0]  in_rs_adr, in_rd_adr;
  logic        in_rs_use, in_rd_use, in_regwrite, in_from_mem;
  logic [23:0] register_invalid;
  logic        flush_decode;
  logic        issue_valid, issue_ready;
  logic [15:0] issue_pc;
  logic [2:0]  issue_rs_adr, issue_rd_adr;
  logic        regwrite_cur;
  logic [2:0]  regwrite_adr_id;
  logic        from_main_mem_id;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs_adr(in_rs_adr), .in_rd_adr(in_rd_adr),
    .in_rs_use(in_rs_use), .in_rd_use(in_rd_use),
    .in_regwrite(in_regwrite), .in_from_mem(in_from_mem),
    .register_invalid(register_invalid), .flush_decode(flush_decode),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pc(issue_pc), .issue_rs_adr(issue_rs_adr), .issue_rd_adr(issue_rd_adr),
    .regwrite_cur(regwrite_cur), .regwrite_adr_id(regwrite_adr_id),
    .from_main_mem_id(from_main_mem_id), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] pc, input logic [2:0] rs, input logic [2:0] rd,
                       input logic rs_use, input logic rd_use, input logic rw, input logic mem);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_rs_adr   = rs;
    in_rd_adr   = rd;
    in_rs_use   = rs_use;
    in_rd_use   = rd_use;
    in_regwrite = rw;
    in_from_mem = mem;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_rs_adr = '0; in_rd_adr = '0;
    in_rs_use = 1'b0; in_rd_use = 1'b0; in_regwrite = 1'b0; in_from_mem = 1'b0;
    register_invalid = '0; flush_decode = 1'b0; issue_ready = 1'b0;

    // Reset: outputs quiet even with an offer pending.
    step(); step();
    in_valid = 1'b1; issue_ready = 1'b1; #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_regwrite", regwrite_cur, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_pc", issue_pc, 0);
    $display("txn reset done");

    // First instruction after reset issues the next cycle.
    reset = 1'b1;
    offer(16'h0010, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("t30_in_ready", in_ready, 1);
    step(); in_valid = 1'b0; #1;
    check("t30_issue_valid", issue_valid, 1);
    check("t30_pc", issue_pc, 16'h0010);
    check("t30_rs", issue_rs_adr, 1);
    check("t30_stall", stall_cnt, 0);
    step();
    check("t30_empty", issue_valid, 0);
    $display("txn first_issue pc=0010");

    // rs=3 hazard with counter 2,1,0.
    offer(16'h0020, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    register_invalid = 24'd2 << 9; #1;
    check("t31_accept", in_ready, 1);
    step(); in_valid = 1'b0; #1;
    check("t31_hz0_valid", issue_valid, 0);
    check("t31_hz0_ready", in_ready, 0);
    step(); register_invalid = 24'd1 << 9; #1;
    check("t31_hz1_valid", issue_valid, 0);
    check("t31_hz1_stall", stall_cnt, 1);
    step(); register_invalid = '0; #1;
    check("t31_go_valid", issue_valid, 1);
    check("t31_stall", stall_cnt, 2);
    step();
    check("t31_stall_after", stall_cnt, 2);
    $display("txn hazard rs=3 stall=%0d", stall_cnt);

    // Four back-to-back independent instructions; all registers busy but unused.
    register_invalid = 24'hFFFFFF;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) offer(16'h0100 + 16'(k), 3'd0, 3'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      else in_valid = 1'b0;
      #1;
      if (k < 4) check("t32_in_ready", in_ready, 1);
      if (k >= 1) begin
        check("t32_valid", issue_valid, 1);
        check("t32_pc", issue_pc, 16'h0100 + 16'(k - 1));
      end
      step();
    end
    check("t32_empty", issue_valid, 0);
    check("t32_stall", stall_cnt, 2);
    register_invalid = '0;
    $display("txn stream4 done");

    // Load rd=5: one stalled cycle, then a single regwrite pulse.
    issue_ready = 1'b0;
    offer(16'h0200, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    step(); in_valid = 1'b0; #1;
    check("t33_wait_valid", issue_valid, 1);
    check("t33_wait_rw", regwrite_cur, 0);
    step(); issue_ready = 1'b1; #1;
    check("t33_rw", regwrite_cur, 1);
    check("t33_adr", regwrite_adr_id, 5);
    check("t33_mem", from_main_mem_id, 1);
    check("t33_rd", issue_rd_adr, 5);
    step();
    check("t33_rw_once", regwrite_cur, 0);
    check("t33_stall", stall_cnt, 3);
    $display("txn load rd=5");

    // Regwrite alone to a busy rd is a hazard.
    offer(16'h0210, 3'd0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    register_invalid = 24'd1 << 18; #1;
    step(); in_valid = 1'b0; #1;
    check("rw_hz_valid", issue_valid, 0);
    check("rw_hz_rw", regwrite_cur, 0);
    step(); register_invalid = '0; #1;
    check("rw_go_rw", regwrite_cur, 1);
    check("rw_go_adr", regwrite_adr_id, 6);
    step();
    check("rw_stall", stall_cnt, 4);
    $display("txn regwrite_hazard rd=6");

    // Flush while held and ready downstream.
    offer(16'h0300, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    step(); flush_decode = 1'b1; #1;
    check("t34_valid", issue_valid, 0);
    check("t34_rw", regwrite_cur, 0);
    check("t34_ready0", in_ready, 0);
    step(); flush_decode = 1'b0; in_valid = 1'b0; #1;
    check("t34_ready1", in_ready, 0);
    check("t34_flush_valid", issue_valid, 0);
    step();
    check("t34_empty_ready", in_ready, 1);
    check("t34_empty_valid", issue_valid, 0);
    check("t34_stall", stall_cnt, 4);
    $display("txn flush pc=0300");

    // Reset mid-operation discards the held instruction.
    offer(16'h0400, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    step(); in_valid = 1'b0; reset = 1'b0; #1;
    check("rmid_rw", regwrite_cur, 0);
    check("rmid_valid", issue_valid, 0);
    step(); reset = 1'b1; #1;
    check("rmid_pc", issue_pc, 0);
    check("rmid_stall", stall_cnt, 0);
    check("rmid_ready", in_ready, 1);
    $display("txn reset_mid_op");

    // Long downstream stall saturates the counter.
    issue_ready = 1'b0;
    offer(16'hBEEF, 3'd7, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0); #1;
    step(); in_valid = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check("t35_stall_fffe", stall_cnt, 16'hFFFE);
    repeat (4466) @(posedge clk);
    #1;
    check("t35_stall_sat", stall_cnt, 16'hFFFF);
    check("t35_pc", issue_pc, 16'hBEEF);
    check("t35_rs", issue_rs_adr, 7);
    check("t35_rd", issue_rd_adr, 4);
    check("t35_valid", issue_valid, 1);
    $display("txn saturation stall=%0h", stall_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
